// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   state_e   : controller FSM states
//   RegAddrW  : default register index width
//   RemainW   : width of the remaining-stall-cycles counter
//   RegX0     : index of the hard-wired zero register
package hazard_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StStall
  } state_e;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RemainW  = 4;

  localparam logic [RegAddrW-1:0] RegX0 = '0;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle between the decode/EX/memory stages and the hazard controller.
//   Inputs to the controller : load-in-EX info, decode operands and use flags,
//                              taken branch, data-memory busy, counter clear.
//   Outputs of the controller: pipeline register write enables, bubble select,
//                              IF/ID flush, stall and flush performance counters.
// master = the pipeline side driving hazard info, slave = the controller.
interface hazard_stall_controller_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
);

  logic                  id_ex_mem_read;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic [REG_ADDR_W-1:0] if_id_rs1;
  logic [REG_ADDR_W-1:0] if_id_rs2;
  logic                  if_id_rs1_used;
  logic                  if_id_rs2_used;
  logic                  ex_branch_taken;
  logic                  dmem_busy;
  logic                  perf_clear;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_write;
  logic                  mux_control;
  logic                  if_id_flush;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2, if_id_rs1_used, if_id_rs2_used,
           ex_branch_taken, dmem_busy, perf_clear,
    input  pc_write, if_id_write, id_ex_write, mux_control, if_id_flush, stall_count,
           flush_count
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2, if_id_rs1_used, if_id_rs2_used,
           ex_branch_taken, dmem_busy, perf_clear,
    output pc_write, if_id_write, id_ex_write, mux_control, if_id_flush, stall_count,
           flush_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, synchronous active-low reset (clears to zero)
//   inc        : count up by one this cycle (ignored once all-ones)
//   clr        : clear to zero at the next edge; wins over inc
//   value      : current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller for the 5-stage core.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of hazard_stall_controller_if (hazard inputs,
//                write enables, bubble/flush controls, perf counters)
// Priority of actions each cycle: reset > dmem freeze > branch flush >
// load-use stall > normal flow. Outputs are Mealy (zero-cycle response).
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W        = RegAddrW,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  hazard_stall_controller_if.slave  bus
);

  localparam logic [RemainW-1:0] RemainInit = RemainW'(LOAD_STALL_CYCLES - 1);

  state_e               state_q, state_d;
  logic [RemainW-1:0]   remain_q, remain_d;
  logic                 hazard;
  logic                 stall_inc;
  logic                 flush_inc;
  logic                 cnt_clr;

  // Load in EX whose destination is read by the instruction in decode; x0 never hazards.
  assign hazard = bus.id_ex_mem_read
                & (bus.id_ex_rd != REG_ADDR_W'(RegX0))
                & ((bus.if_id_rs1_used & (bus.id_ex_rd == bus.if_id_rs1))
                 | (bus.if_id_rs2_used & (bus.id_ex_rd == bus.if_id_rs2)));

  always_comb begin
    state_d         = state_q;
    remain_d        = remain_q;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.id_ex_write = 1'b1;
    bus.mux_control = 1'b0;
    bus.if_id_flush = 1'b0;

    if (!rst_n) begin
      // Fill the pipeline with bubbles while in reset.
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.id_ex_write = 1'b1;
      bus.mux_control = 1'b1;
      bus.if_id_flush = 1'b1;
    end else if (bus.dmem_busy) begin
      // Freeze: EX keeps presenting a pending branch, so the flush is taken afterwards.
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.id_ex_write = 1'b0;
    end else if (bus.ex_branch_taken) begin
      bus.mux_control = 1'b1;
      bus.if_id_flush = 1'b1;
      state_d         = StIdle;
      remain_d        = '0;
      flush_inc       = 1'b1;
    end else if ((state_q == StStall) || hazard) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.mux_control = 1'b1;
      stall_inc       = 1'b1;
      if (state_q == StIdle) begin
        if (LOAD_STALL_CYCLES > 1) begin
          state_d  = StStall;
          remain_d = RemainInit;
        end
      end else if (remain_q <= RemainW'(1)) begin
        state_d  = StIdle;
        remain_d = '0;
      end else begin
        remain_d = remain_q - RemainW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  assign cnt_clr = bus.perf_clear;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .value (bus.stall_count)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (cnt_clr),
    .value (bus.flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed, table-driven bench for hazard_stall_controller.
// dut_a: LOAD_STALL_CYCLES=1, CNT_W=32. dut_b: LOAD_STALL_CYCLES=3, CNT_W=4.
module tb_hazard_stall_controller;

  // Output pattern {pc_write, if_id_write, id_ex_write, mux_control, if_id_flush}
  localparam logic [4:0] PNorm   = 5'b11100;
  localparam logic [4:0] PStall  = 5'b00110;
  localparam logic [4:0] PFlush  = 5'b11111;
  localparam logic [4:0] PFreeze = 5'b00000;
  localparam logic [4:0] PRst    = 5'b00111;

  typedef struct {
    int         sel;
    bit         rst_n;
    bit         mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit         u1;
    bit         u2;
    bit         br;
    bit         busy;
    bit         clr;
    logic [4:0] exp_out;
    int         exp_stall;
    int         exp_flush;
  } vec_t;

  logic clk;
  logic rst_a, rst_b;
  int   total, bad;
  vec_t vecs[$];

  hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(32)) bus_a ();
  hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(4))  bus_b ();

  hazard_stall_controller #(
    .REG_ADDR_W        (5),
    .LOAD_STALL_CYCLES (1),
    .CNT_W             (32)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (bus_a)
  );

  hazard_stall_controller #(
    .REG_ADDR_W        (5),
    .LOAD_STALL_CYCLES (3),
    .CNT_W             (4)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int sel, bit rst_n, bit mr, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, bit u1, bit u2, bit br, bit busy, bit clr,
                              logic [4:0] exp_out, int exp_stall, int exp_flush);
    vec_t v;
    v.sel = sel; v.rst_n = rst_n; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.u1 = u1; v.u2 = u2; v.br = br; v.busy = busy; v.clr = clr;
    v.exp_out = exp_out; v.exp_stall = exp_stall; v.exp_flush = exp_flush;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic idle_a();
    bus_a.id_ex_mem_read = 0; bus_a.id_ex_rd = 0; bus_a.if_id_rs1 = 0; bus_a.if_id_rs2 = 0;
    bus_a.if_id_rs1_used = 0; bus_a.if_id_rs2_used = 0; bus_a.ex_branch_taken = 0;
    bus_a.dmem_busy = 0; bus_a.perf_clear = 0;
  endtask

  task automatic idle_b();
    bus_b.id_ex_mem_read = 0; bus_b.id_ex_rd = 0; bus_b.if_id_rs1 = 0; bus_b.if_id_rs2 = 0;
    bus_b.if_id_rs1_used = 0; bus_b.if_id_rs2_used = 0; bus_b.ex_branch_taken = 0;
    bus_b.dmem_busy = 0; bus_b.perf_clear = 0;
  endtask

  // Drive at the falling edge, check 1ns later, the DUT acts on the next rising edge.
  task automatic apply(input vec_t v, input int idx);
    logic [4:0] outs;
    logic [31:0] sc, fc;
    @(negedge clk);
    idle_a();
    idle_b();
    rst_a = 1'b1;
    rst_b = 1'b1;
    if (v.sel == 0) begin
      rst_a = v.rst_n;
      bus_a.id_ex_mem_read = v.mr; bus_a.id_ex_rd = v.rd;
      bus_a.if_id_rs1 = v.rs1; bus_a.if_id_rs2 = v.rs2;
      bus_a.if_id_rs1_used = v.u1; bus_a.if_id_rs2_used = v.u2;
      bus_a.ex_branch_taken = v.br; bus_a.dmem_busy = v.busy; bus_a.perf_clear = v.clr;
    end else begin
      rst_b = v.rst_n;
      bus_b.id_ex_mem_read = v.mr; bus_b.id_ex_rd = v.rd;
      bus_b.if_id_rs1 = v.rs1; bus_b.if_id_rs2 = v.rs2;
      bus_b.if_id_rs1_used = v.u1; bus_b.if_id_rs2_used = v.u2;
      bus_b.ex_branch_taken = v.br; bus_b.dmem_busy = v.busy; bus_b.perf_clear = v.clr;
    end
    #1;
    if (v.sel == 0) begin
      outs = {bus_a.pc_write, bus_a.if_id_write, bus_a.id_ex_write, bus_a.mux_control,
              bus_a.if_id_flush};
      sc = bus_a.stall_count;
      fc = bus_a.flush_count;
    end else begin
      outs = {bus_b.pc_write, bus_b.if_id_write, bus_b.id_ex_write, bus_b.mux_control,
              bus_b.if_id_flush};
      sc = 32'(bus_b.stall_count);
      fc = 32'(bus_b.flush_count);
    end
    check("outputs", idx, 32'(outs), 32'(v.exp_out));
    check("stall_count", idx, sc, v.exp_stall);
    check("flush_count", idx, fc, v.exp_flush);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle_a();
    idle_b();
    repeat (2) @(posedge clk);

    // Reset state: bubble pattern on both instances, counters cleared.
    @(negedge clk);
    check("rst_out_a", -1, 32'({bus_a.pc_write, bus_a.if_id_write, bus_a.id_ex_write,
                                bus_a.mux_control, bus_a.if_id_flush}), 32'(PRst));
    check("rst_out_b", -1, 32'({bus_b.pc_write, bus_b.if_id_write, bus_b.id_ex_write,
                                bus_b.mux_control, bus_b.if_id_flush}), 32'(PRst));
    check("rst_cnt_a", -1, bus_a.stall_count, 32'd0);
    check("rst_cnt_b", -1, 32'(bus_b.flush_count), 32'd0);

    //          sel rst mr rd rs1 rs2 u1 u2 br bsy clr  out  stall flush
    // dut_a, single-cycle load stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PRst,    0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PNorm,   0, 0));
    vecs.push_back(mk(0, 1, 1, 5, 5, 0, 1, 0, 0, 0, 0, PStall,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, PNorm,   1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, PNorm,   1, 0));  // rd = x0
    vecs.push_back(mk(0, 1, 1, 7, 3, 7, 1, 0, 0, 0, 0, PNorm,   1, 0));  // rs2 not used
    vecs.push_back(mk(0, 1, 1, 7, 3, 7, 1, 1, 0, 0, 0, PStall,  1, 0));
    vecs.push_back(mk(0, 1, 1, 7, 3, 7, 1, 1, 1, 0, 0, PFlush,  2, 0));  // flush beats hazard
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PNorm,   2, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, PFreeze, 2, 1));  // freeze beats flush
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, PFlush,  2, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, PNorm,   2, 2));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PNorm,   0, 0));
    // dut_b, three-cycle load stall from a one-cycle hazard
    vecs.push_back(mk(1, 1, 1, 5, 5, 0, 1, 0, 0, 0, 0, PStall,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PStall,  1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PStall,  2, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, PNorm,   3, 0));
    // branch in the second stall cycle aborts the stall
    vecs.push_back(mk(1, 1, 1, 5, 0, 5, 0, 1, 0, 0, 0, PStall,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, PFlush,  1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PNorm,   1, 1));
    // dmem busy for 4 cycles mid-stall, remaining stall cycles then complete
    vecs.push_back(mk(1, 1, 1, 9, 9, 0, 1, 0, 0, 0, 0, PStall,  1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, PFreeze, 2, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, PFreeze, 2, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, PFreeze, 2, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, PFreeze, 2, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PStall,  2, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PStall,  3, 1));
    // fresh hazard straight after a stall period
    vecs.push_back(mk(1, 1, 1, 4, 0, 4, 0, 1, 0, 0, 0, PStall,  4, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PStall,  5, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PStall,  6, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PNorm,   7, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Saturation of the 4-bit stall counter: hazard held for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      apply(mk(1, 1, 1, 5, 5, 0, 1, 0, 0, 0, 0, PStall, (7 + i > 15) ? 15 : 7 + i, 1), 100 + i);
    end
    // Clear together with a stall cycle: clear wins.
    apply(mk(1, 1, 1, 5, 5, 0, 1, 0, 0, 0, 1, PStall, 15, 1), 120);
    // Enter STALL, then reset mid-stall; afterwards the FSM must be idle.
    apply(mk(1, 1, 1, 5, 5, 0, 1, 0, 0, 0, 0, PStall,  0, 0), 121);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PRst,    1, 0), 122);
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, PNorm,   0, 0), 123);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
